// File: rtl/core_obuf_pkg.sv
// Shared widths, derived sizes and serializer state encoding for core_obuf.
package core_obuf_pkg;

  // Default configuration of the per-core output buffer
  localparam int DEF_GBUS_DATA   = 64;
  localparam int DEF_OBUF_DATA   = 256;
  localparam int DEF_OBUF_DEPTH  = 16;
  localparam int DEF_ALERT_DEPTH = 3;

  // Derived sizes for the default configuration
  localparam int DEF_REG_NUM   = DEF_OBUF_DATA / DEF_GBUS_DATA;
  localparam int DEF_OBUF_ADDR = $clog2(DEF_OBUF_DEPTH);

  // Beat counter width; kept at least one bit so a single-beat word still works
  function automatic int beat_bits(input int reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  localparam int DEF_BEAT_BITS = beat_bits(DEF_REG_NUM);

  // Serializer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

endpackage

// File: rtl/core_obuf_if.sv
// Global-bus transmit link carried from core_obuf toward the core-to-core fabric.
// Optional macro: CORE_OBUF_LAST_EN adds gbus_wlast.
//
// Handshake: a beat transfers on a rising clk edge where gbus_wvalid and
// gbus_wready are both high. Once gbus_wvalid rises, gbus_wvalid, gbus_wdata
// (and gbus_wlast) stay unchanged until that transfer; only a flush or reset
// may withdraw a pending beat. gbus_wready may be held low for any length.
interface core_obuf_if #(
  parameter int GBUS_DATA = 64
) ();

  logic [GBUS_DATA-1:0] gbus_wdata;
  logic                 gbus_wvalid;
  logic                 gbus_wready;
`ifdef CORE_OBUF_LAST_EN
  logic                 gbus_wlast;
`endif

`ifdef CORE_OBUF_LAST_EN
  modport master (output gbus_wdata, output gbus_wvalid, output gbus_wlast, input gbus_wready);
  modport slave  (input gbus_wdata, input gbus_wvalid, input gbus_wlast, output gbus_wready);
`else
  modport master (output gbus_wdata, output gbus_wvalid, input gbus_wready);
  modport slave  (input gbus_wdata, input gbus_wvalid, output gbus_wready);
`endif

endinterface

// File: rtl/core_obuf_p2s.sv
// Parallel-to-serial stage: pulls result words from the FIFO and emits them
// LSB slice first as GBUS_DATA-wide beats.
// Optional macro: CORE_OBUF_LAST_EN adds gbus_wlast on the final beat.
module align_p2s_obuf
  import core_obuf_pkg::*;
#(
  parameter int GBUS_DATA = DEF_GBUS_DATA,
  parameter int OBUF_DATA = DEF_OBUF_DATA
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 empty,
  output logic                 ren,
  input  logic [OBUF_DATA-1:0] rdata,
  output logic [GBUS_DATA-1:0] gbus_wdata,
  output logic                 gbus_wvalid,
  input  logic                 gbus_wready,
`ifdef CORE_OBUF_LAST_EN
  output logic                 gbus_wlast,
`endif
  output state_e               state
);

  localparam int REG_NUM   = OBUF_DATA / GBUS_DATA;
  localparam int BEAT_BITS = beat_bits(REG_NUM);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(REG_NUM - 1);

  state_e                 state_q, state_d;
  logic [OBUF_DATA-1:0]   shift_q, shift_d;
  logic [BEAT_BITS-1:0]   beat_q,  beat_d;

  // State, shift register and beat counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shift_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic: fetch a word, then shift it out one beat per handshake
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    ren     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      shift_d = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            ren     = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: begin
          // rdata holds the word requested in the previous cycle
          shift_d = rdata;
          beat_d  = '0;
          state_d = SEND;
        end
        SEND: begin
          if (gbus_wready) begin
            shift_d = shift_q >> GBUS_DATA;
            beat_d  = beat_q + BEAT_BITS'(1);
            if (beat_q == LAST_BEAT) begin
              beat_d = '0;
              // Chain straight into the next word to keep the bubble to one cycle
              if (!empty) begin
                ren     = 1'b1;
                state_d = FETCH;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Bus outputs follow registered state only, so they hold under backpressure
  always_comb begin
    gbus_wvalid = (state_q == SEND);
    gbus_wdata  = gbus_wvalid ? shift_q[GBUS_DATA-1:0] : '0;
`ifdef CORE_OBUF_LAST_EN
    gbus_wlast  = gbus_wvalid && (beat_q == LAST_BEAT);
`endif
    state       = state_q;
  end

endmodule

// File: rtl/core_obuf.sv
// Per-core output buffer: result-word FIFO feeding a serializer onto the
// global bus. Optional macro: CORE_OBUF_LAST_EN adds gbus_wlast.
module core_obuf
  import core_obuf_pkg::*;
#(
  parameter int GBUS_DATA   = DEF_GBUS_DATA,
  parameter int OBUF_DATA   = DEF_OBUF_DATA,
  parameter int OBUF_DEPTH  = DEF_OBUF_DEPTH,
  parameter int ALERT_DEPTH = DEF_ALERT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          obuf_flush,
  input  logic [OBUF_DATA-1:0]          obuf_wdata,
  input  logic                          obuf_wen,
  output logic                          obuf_full,
  output logic                          obuf_almost_full,
  output logic                          obuf_empty,
  output logic [$clog2(OBUF_DEPTH):0]   obuf_count,
  output logic                          obuf_overflow,
  output logic                          obuf_busy,
  output state_e                        obuf_state,
  core_obuf_if.master                   gbus
);

  localparam int OBUF_ADDR = $clog2(OBUF_DEPTH);
  localparam logic [OBUF_ADDR:0] ALERT_LEVEL = (OBUF_ADDR+1)'(OBUF_DEPTH - ALERT_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [OBUF_ADDR:0]   waddr_q, waddr_d;
  logic [OBUF_ADDR:0]   raddr_q, raddr_d;
  logic                 ovf_q,   ovf_d;
  logic [OBUF_DATA-1:0] mem_q [OBUF_DEPTH];
  logic [OBUF_DATA-1:0] rdata_q;
  logic                 wr_accept;
  logic                 ren;
  logic                 full;
  logic                 empty;
  state_e               p2s_state;

  // Pointer and sticky overflow registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr_q <= '0;
      raddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status flags and pointer updates; flush overrides any write or read
  always_comb begin
    empty     = (waddr_q == raddr_q);
    full      = (waddr_q[OBUF_ADDR] != raddr_q[OBUF_ADDR]) &&
                (waddr_q[OBUF_ADDR-1:0] == raddr_q[OBUF_ADDR-1:0]);
    wr_accept = obuf_wen && !full && !obuf_flush;
    waddr_d   = waddr_q + {{OBUF_ADDR{1'b0}}, wr_accept};
    raddr_d   = raddr_q + {{OBUF_ADDR{1'b0}}, ren};
    ovf_d     = ovf_q | (obuf_wen & full);
    if (obuf_flush) begin
      waddr_d = '0;
      raddr_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // Word storage with synchronous read
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[waddr_q[OBUF_ADDR-1:0]] <= obuf_wdata;
    end
    if (ren) begin
      rdata_q <= mem_q[raddr_q[OBUF_ADDR-1:0]];
    end
  end

  align_p2s_obuf #(
    .GBUS_DATA (GBUS_DATA),
    .OBUF_DATA (OBUF_DATA)
  ) u_p2s (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (obuf_flush),
    .empty       (empty),
    .ren         (ren),
    .rdata       (rdata_q),
    .gbus_wdata  (gbus.gbus_wdata),
    .gbus_wvalid (gbus.gbus_wvalid),
    .gbus_wready (gbus.gbus_wready),
`ifdef CORE_OBUF_LAST_EN
    .gbus_wlast  (gbus.gbus_wlast),
`endif
    .state       (p2s_state)
  );

  // Externally visible status
  always_comb begin
    obuf_count       = waddr_q - raddr_q;
    obuf_full        = full;
    obuf_empty       = empty;
    obuf_almost_full = (obuf_count >= ALERT_LEVEL);
    obuf_overflow    = ovf_q;
    obuf_busy        = (p2s_state != IDLE);
    obuf_state       = p2s_state;
  end

endmodule
